// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the minimal x87-style FPU core.
// Holds the internal opcode values, the constant ROM, the tag encodings,
// the indefinite value, the control word reset value and the core FSM states.
package fpu_pkg;

    localparam logic [7:0] OP_FNOP   = 8'h00;
    localparam logic [7:0] OP_FINIT  = 8'h01;
    localparam logic [7:0] OP_FILD   = 8'h10;
    localparam logic [7:0] OP_FLD    = 8'h20;
    localparam logic [7:0] OP_FST    = 8'h21;
    localparam logic [7:0] OP_FSTP   = 8'h22;
    localparam logic [7:0] OP_FXCH   = 8'h23;
    localparam logic [7:0] OP_FLD1   = 8'h80;
    localparam logic [7:0] OP_FLDZ   = 8'h81;
    localparam logic [7:0] OP_FLDPI  = 8'h82;
    localparam logic [7:0] OP_FLDL2E = 8'h83;
    localparam logic [7:0] OP_FLDL2T = 8'h84;
    localparam logic [7:0] OP_FLDLG2 = 8'h85;
    localparam logic [7:0] OP_FLDLN2 = 8'h86;

    localparam logic [1:0] TAG_VALID = 2'b00;
    localparam logic [1:0] TAG_ZERO  = 2'b01;
    localparam logic [1:0] TAG_EMPTY = 2'b11;

    localparam logic [79:0] INDEFINITE      = 80'hFFFF_C000_0000_0000_0000;
    localparam logic [15:0] CONTROL_DEFAULT = 16'h037F;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } core_state_t;

    // Zero tag means exponent and mantissa are both zero; the sign is ignored.
    function automatic logic [1:0] tag_of(input logic [79:0] value);
        return (value[78:0] == 79'd0) ? TAG_ZERO : TAG_VALID;
    endfunction

    // Constant ROM addressed by the low opcode bits of 0x80..0x86.
    function automatic logic [79:0] const_rom(input logic [2:0] sel);
        case (sel)
            3'd0:    return 80'h3FFF_8000_0000_0000_0000;  // 1.0
            3'd1:    return 80'h0000_0000_0000_0000_0000;  // +0.0
            3'd2:    return 80'h4000_C90F_DAA2_2168_C235;  // pi
            3'd3:    return 80'h3FFF_B8AA_3B29_5C17_F0BC;  // log2(e)
            3'd4:    return 80'h4000_D49A_784B_CD1B_8AFE;  // log2(10)
            3'd5:    return 80'h3FFD_9A20_9A84_FBCF_F799;  // log10(2)
            3'd6:    return 80'h3FFE_B172_17F7_D1CF_79AC;  // ln(2)
            default: return 80'h0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_if.sv
// fpu_if: bundle between the ESC-instruction decoder (master) and the FPU
// core (slave). Carries the pre-decoded opcode, memory operands, the
// execute/ready handshake, results and the architectural status words.
//
// Handshake: the decoder raises execute for one cycle; the core accepts it
// only on a rising edge where ready is 1. ready then drops for exactly one
// cycle and rises again; execute seen while ready is 0 is ignored.
interface fpu_if;
    import fpu_pkg::*;

    logic [7:0]  instruction;
    logic [2:0]  stack_index;
    logic        execute;
    logic        ready;
    logic        error;
    logic [79:0] data_in;
    logic [79:0] data_out;
    logic [31:0] int_data_in;
    logic [31:0] int_data_out;
    logic        has_memory_op;
    logic [1:0]  operand_size;
    logic        is_integer;
    logic        is_bcd;
    logic [15:0] control_in;
    logic        control_write;
    logic [15:0] status_out;
    logic [15:0] control_out;
    logic [15:0] tag_word_out;
    core_state_t fsm_state;

    modport master (
        output instruction, stack_index, execute, data_in, int_data_in,
               has_memory_op, operand_size, is_integer, is_bcd,
               control_in, control_write,
        input  ready, error, data_out, int_data_out, status_out,
               control_out, tag_word_out, fsm_state
    );

    modport slave (
        input  instruction, stack_index, execute, data_in, int_data_in,
               has_memory_op, operand_size, is_integer, is_bcd,
               control_in, control_write,
        output ready, error, data_out, int_data_out, status_out,
               control_out, tag_word_out, fsm_state
    );

endinterface

// File: rtl/fpu_register_stack.sv
// fpu_register_stack: eight 80-bit physical registers with TOP pointer and
// per-register 2-bit tags.
// Ports: clk/reset; init (FINIT: TOP=0, all tags empty); push/push_value;
// pop; xchg with xchg_st0/xchg_sti (new values for ST(0) and ST(st_index));
// st_index selects ST(i). Outputs st0/sti values with empty flags,
// push_full (phys[TOP-1] occupied), top and the packed tag word.
module fpu_register_stack
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        push,
    input  logic [79:0] push_value,
    input  logic        pop,
    input  logic        xchg,
    input  logic [79:0] xchg_st0,
    input  logic [79:0] xchg_sti,
    input  logic [2:0]  st_index,
    output logic [79:0] st0,
    output logic [79:0] sti,
    output logic        st0_empty,
    output logic        sti_empty,
    output logic        push_full,
    output logic [2:0]  top,
    output logic [15:0] tags
);

    logic [79:0] phys [8];
    logic [1:0]  tag  [8];
    logic [2:0]  top_q;
    logic [2:0]  top_dec;
    logic [2:0]  sti_addr;

    // 3-bit arithmetic gives the mod-8 wrap for free.
    assign top_dec  = top_q - 3'd1;
    assign sti_addr = top_q + st_index;

    assign st0       = phys[top_q];
    assign sti       = phys[sti_addr];
    assign st0_empty = (tag[top_q] == TAG_EMPTY);
    assign sti_empty = (tag[sti_addr] == TAG_EMPTY);
    assign push_full = (tag[top_dec] != TAG_EMPTY);
    assign top       = top_q;

    always_comb begin
        tags = '0;
        for (int k = 0; k < 8; k++) begin
            tags[2*k +: 2] = tag[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                phys[k] <= '0;
                tag[k]  <= TAG_EMPTY;
            end
        end else if (init) begin
            // FINIT leaves register contents alone; only tags and TOP reset.
            top_q <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                tag[k] <= TAG_EMPTY;
            end
        end else if (push) begin
            top_q         <= top_dec;
            phys[top_dec] <= push_value;
            tag[top_dec]  <= tag_of(push_value);
        end else if (pop) begin
            tag[top_q] <= TAG_EMPTY;
            top_q      <= top_q + 3'd1;
        end else if (xchg) begin
            // For ST(0) both addresses coincide and both values are equal.
            phys[sti_addr] <= xchg_sti;
            tag[sti_addr]  <= tag_of(xchg_sti);
            phys[top_q]    <= xchg_st0;
            tag[top_q]     <= tag_of(xchg_st0);
        end
    end

endmodule

// File: rtl/fpu_core.sv
// fpu_core: minimal x87-style FPU executing constant loads, FLD/FST/FSTP,
// FXCH, FILD m32int, FINIT and FNOP with one busy cycle per instruction.
// Ports: clk, reset (synchronous, active-high) and the fpu_if slave bundle
// (opcode/operands in; ready, error, data_out, status/control/tag words and
// the FSM state out).
module fpu_core
    import fpu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    fpu_if.slave  bus
);

    core_state_t state_q;
    logic        ready_q;
    logic [79:0] data_out_q;
    logic        ie_q, sf_q, c1_q;
    logic [15:0] control_q;
    logic        es;
    logic        accept;

    logic [79:0] st0, sti;
    logic        st0_empty, sti_empty, push_full;
    logic [2:0]  top;
    logic [15:0] tags;

    logic        push_en, pop_en, xchg_en, store_en, finit;
    logic [79:0] push_value, xchg_st0, xchg_sti, store_value;
    logic        set_ie, set_sf, c1_write, c1_value;

    logic [31:0] int_mag;
    logic [4:0]  msb;
    logic [63:0] fild_mant;
    logic [79:0] fild_value;
    logic        unused_bits;

    assign unused_bits = ^{bus.operand_size, bus.is_integer};

    assign accept = (state_q == ST_IDLE) && bus.execute;
    assign es     = ie_q & ~control_q[0];

    // FILD: magnitude, leading-one position, then normalise so the explicit
    // integer bit lands at mantissa bit 63. Every int32 converts exactly.
    always_comb begin
        int_mag = bus.int_data_in[31] ? (~bus.int_data_in + 32'd1) : bus.int_data_in;
        msb = 5'd0;
        for (int k = 0; k < 32; k++) begin
            if (int_mag[k]) msb = 5'(k);
        end
        fild_mant  = {32'd0, int_mag} << (6'd63 - {1'b0, msb});
        fild_value = (int_mag == 32'd0) ? 80'd0
                   : {bus.int_data_in[31], 15'd16383 + {10'd0, msb}, fild_mant};
    end

    always_comb begin
        push_en     = 1'b0;
        push_value  = '0;
        pop_en      = 1'b0;
        xchg_en     = 1'b0;
        xchg_st0    = '0;
        xchg_sti    = '0;
        store_en    = 1'b0;
        store_value = '0;
        finit       = 1'b0;
        set_ie      = 1'b0;
        set_sf      = 1'b0;
        c1_write    = 1'b0;
        c1_value    = 1'b0;
        if (bus.is_bcd) begin
            set_ie = 1'b1;
        end else begin
            case (bus.instruction)
                OP_FNOP: begin end
                OP_FINIT: finit = 1'b1;
                OP_FILD: begin
                    push_en    = 1'b1;
                    push_value = fild_value;
                end
                OP_FLD: begin
                    push_en = 1'b1;
                    if (bus.has_memory_op) begin
                        push_value = bus.data_in;
                    end else if (sti_empty) begin
                        push_value = INDEFINITE;
                        set_ie     = 1'b1;
                        set_sf     = 1'b1;
                        c1_write   = 1'b1;
                    end else begin
                        push_value = sti;
                    end
                end
                OP_FST, OP_FSTP: begin
                    store_en    = 1'b1;
                    pop_en      = (bus.instruction == OP_FSTP);
                    store_value = st0_empty ? INDEFINITE : st0;
                    if (st0_empty) begin
                        set_ie   = 1'b1;
                        set_sf   = 1'b1;
                        c1_write = 1'b1;
                    end
                end
                OP_FXCH: begin
                    xchg_en  = 1'b1;
                    xchg_st0 = sti_empty ? INDEFINITE : sti;
                    xchg_sti = st0_empty ? INDEFINITE : st0;
                    if (st0_empty || sti_empty) begin
                        set_ie   = 1'b1;
                        set_sf   = 1'b1;
                        c1_write = 1'b1;
                    end
                end
                OP_FLD1, OP_FLDZ, OP_FLDPI, OP_FLDL2E,
                OP_FLDL2T, OP_FLDLG2, OP_FLDLN2: begin
                    push_en    = 1'b1;
                    push_value = const_rom(bus.instruction[2:0]);
                end
                default: set_ie = 1'b1;
            endcase
            // Overflow outranks any underflow from the FLD ST(i) source.
            if (push_en && push_full) begin
                push_value = INDEFINITE;
                set_ie     = 1'b1;
                set_sf     = 1'b1;
                c1_write   = 1'b1;
                c1_value   = 1'b1;
            end
        end
    end

    fpu_register_stack register_stack (
        .clk        (clk),
        .reset      (reset),
        .init       (accept && finit),
        .push       (accept && push_en),
        .push_value (push_value),
        .pop        (accept && pop_en),
        .xchg       (accept && xchg_en),
        .xchg_st0   (xchg_st0),
        .xchg_sti   (xchg_sti),
        .st_index   (bus.stack_index),
        .st0        (st0),
        .sti        (sti),
        .st0_empty  (st0_empty),
        .sti_empty  (sti_empty),
        .push_full  (push_full),
        .top        (top),
        .tags       (tags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            data_out_q <= '0;
            ie_q       <= 1'b0;
            sf_q       <= 1'b0;
            c1_q       <= 1'b0;
            control_q  <= CONTROL_DEFAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.execute) begin
                        state_q <= ST_BUSY;
                        ready_q <= 1'b0;
                        if (finit) begin
                            ie_q      <= 1'b0;
                            sf_q      <= 1'b0;
                            c1_q      <= 1'b0;
                            control_q <= CONTROL_DEFAULT;
                        end
                        if (store_en) data_out_q <= store_value;
                        if (set_ie)   ie_q <= 1'b1;
                        if (set_sf)   sf_q <= 1'b1;
                        if (c1_write) c1_q <= c1_value;
                    end
                end
                ST_BUSY: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            // A control word load wins over FINIT in the same cycle.
            if (bus.control_write) control_q <= bus.control_in;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.error        = es;
    assign bus.data_out     = data_out_q;
    assign bus.int_data_out = '0;
    assign bus.status_out   = {2'b00, top, 1'b0, c1_q, 1'b0, es, sf_q, 5'b00000, ie_q};
    assign bus.control_out  = control_q;
    assign bus.tag_word_out = tags;
    assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_fpu_core.sv
// tb_fpu_core: directed test of fpu_core against a behavioural stack model,
// with a per-cycle compare process plus literal spot checks.
module tb_fpu_core;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpu_if bus ();
    fpu_core dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;

    // Model state
    logic [79:0] m_reg [8];
    logic [1:0]  m_tag [8];
    int          m_top;
    logic        m_ie, m_sf, m_c1;
    logic [15:0] m_ctrl;
    logic [79:0] m_dout;
    logic        exp_ready;
    bit          checking = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] m_tagof(input logic [79:0] v);
        return (v[78:64] == 15'd0 && v[63:0] == 64'd0) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [79:0] m_const(input int k);
        case (k)
            0: return 80'h3FFF8000000000000000;
            1: return 80'h0;
            2: return 80'h4000C90FDAA22168C235;
            3: return 80'h3FFFB8AA3B295C17F0BC;
            4: return 80'h4000D49A784BCD1B8AFE;
            5: return 80'h3FFD9A209A84FBCFF799;
            default: return 80'h3FFEB17217F7D1CF79AC;
        endcase
    endfunction

    // Exact int32 -> extended real: value = mag * 2^0, normalised.
    function automatic logic [79:0] m_int_to_ext(input logic [31:0] i);
        longint s;
        longint unsigned mag;
        int p;
        logic [14:0] e;
        logic [63:0] m;
        s = longint'($signed(i));
        if (s == 0) return 80'd0;
        mag = (s < 0) ? longint'(-s) : longint'(s);
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = 15'(16383 + p);
        m = 64'(mag << (63 - p));
        return {i[31], e, m};
    endfunction

    function automatic logic [15:0] exp_status();
        logic es;
        es = m_ie & ~m_ctrl[0];
        return {2'b00, 3'(m_top), 1'b0, m_c1, 1'b0, es, m_sf, 5'b00000, m_ie};
    endfunction

    function automatic logic [15:0] exp_tags();
        logic [15:0] t;
        for (int k = 0; k < 8; k++) t[2*k +: 2] = m_tag[k];
        return t;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) begin
            m_reg[k] = '0;
            m_tag[k] = 2'b11;
        end
        m_top = 0; m_ie = 0; m_sf = 0; m_c1 = 0;
        m_ctrl = 16'h037F; m_dout = '0;
    endtask

    task automatic m_push(input logic [79:0] v);
        int nt;
        logic [79:0] w;
        w = v;
        nt = (m_top + 7) % 8;
        if (m_tag[nt] != 2'b11) begin
            w = INDEF; m_ie = 1; m_sf = 1; m_c1 = 1;
        end
        m_top = nt;
        m_reg[nt] = w;
        m_tag[nt] = m_tagof(w);
    endtask

    task automatic m_exec(input logic [7:0] op, input logic [2:0] idx, input logic mem,
                          input logic [79:0] din, input logic [31:0] idin, input logic bcd);
        int a, b;
        logic [79:0] va, vb;
        if (bcd) begin
            m_ie = 1;
            return;
        end
        a = m_top;
        b = (m_top + int'(idx)) % 8;
        case (op)
            8'h00: ;
            8'h01: begin
                m_top = 0;
                for (int k = 0; k < 8; k++) m_tag[k] = 2'b11;
                m_ie = 0; m_sf = 0; m_c1 = 0; m_ctrl = 16'h037F;
            end
            8'h10: m_push(m_int_to_ext(idin));
            8'h20: begin
                if (mem) m_push(din);
                else if (m_tag[b] == 2'b11) begin
                    m_ie = 1; m_sf = 1; m_c1 = 0;
                    m_push(INDEF);
                end else m_push(m_reg[b]);
            end
            8'h21, 8'h22: begin
                if (m_tag[a] == 2'b11) begin
                    m_dout = INDEF; m_ie = 1; m_sf = 1; m_c1 = 0;
                end else m_dout = m_reg[a];
                if (op == 8'h22) begin
                    m_tag[a] = 2'b11;
                    m_top = (m_top + 1) % 8;
                end
            end
            8'h23: begin
                va = (m_tag[a] == 2'b11) ? INDEF : m_reg[a];
                vb = (m_tag[b] == 2'b11) ? INDEF : m_reg[b];
                if (m_tag[a] == 2'b11 || m_tag[b] == 2'b11) begin
                    m_ie = 1; m_sf = 1; m_c1 = 0;
                end
                m_reg[b] = va; m_tag[b] = m_tagof(va);
                m_reg[a] = vb; m_tag[a] = m_tagof(vb);
            end
            default: begin
                if (op >= 8'h80 && op <= 8'h86) m_push(m_const(int'(op - 8'h80)));
                else m_ie = 1;
            end
        endcase
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("ready", bus.ready, exp_ready);
            check("error", bus.error, m_ie & ~m_ctrl[0]);
            check("data_out", bus.data_out, m_dout);
            check("int_data_out", bus.int_data_out, 32'd0);
            check("status", bus.status_out, exp_status());
            check("control", bus.control_out, m_ctrl);
            check("tag_word", bus.tag_word_out, exp_tags());
        end
    end

    task automatic issue(input logic [7:0] op, input logic [2:0] idx = 3'd0,
                         input logic mem = 1'b0, input logic [79:0] din = '0,
                         input logic [31:0] idin = '0, input logic bcd = 1'b0,
                         input logic hold = 1'b0, input logic cw = 1'b0,
                         input logic [15:0] cwv = '0);
        @(negedge clk);
        bus.instruction = op; bus.stack_index = idx; bus.has_memory_op = mem;
        bus.data_in = din; bus.int_data_in = idin; bus.is_bcd = bcd;
        bus.is_integer = (op == 8'h10);
        bus.operand_size = (op == 8'h10) ? 2'd0 : 2'd3;
        bus.control_write = cw; bus.control_in = cwv;
        bus.execute = 1'b1;
        @(posedge clk);
        m_exec(op, idx, mem, din, idin, bcd);
        if (cw) m_ctrl = cwv;
        exp_ready = 1'b0;
        @(negedge clk);
        bus.control_write = 1'b0;
        if (!hold) bus.execute = 1'b0;
        @(posedge clk);
        exp_ready = 1'b1;
        #1 bus.execute = 1'b0;
    endtask

    task automatic set_control(input logic [15:0] v);
        @(negedge clk);
        bus.control_in = v; bus.control_write = 1'b1;
        @(posedge clk);
        m_ctrl = v;
        @(negedge clk);
        bus.control_write = 1'b0;
        #1;
    endtask

    initial begin
        bus.instruction = 8'h00; bus.stack_index = 3'd0; bus.execute = 1'b0;
        bus.data_in = '0; bus.int_data_in = '0; bus.has_memory_op = 1'b0;
        bus.operand_size = 2'd3; bus.is_integer = 1'b0; bus.is_bcd = 1'b0;
        bus.control_in = '0; bus.control_write = 1'b0;
        m_reset();
        exp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checking = 1;
        #1;
        check("reset_status", bus.status_out, 16'h0000);
        check("reset_control", bus.control_out, 16'h037F);
        check("reset_tags", bus.tag_word_out, 16'hFFFF);
        check("reset_ready", bus.ready, 1'b1);
        check("reset_st0", dut.register_stack.st0, 80'h0);

        // FLD1 / FSTP
        issue(8'h80);
        check("fld1_st0", dut.register_stack.st0, 80'h3FFF8000000000000000);
        check("fld1_tags", bus.tag_word_out, 16'h3FFF);
        check("fld1_status", bus.status_out, 16'h3800);
        issue(8'h22);
        check("fstp1_data", bus.data_out, 80'h3FFF8000000000000000);
        check("fstp1_status", bus.status_out, 16'h0000);
        check("fstp1_tags", bus.tag_word_out, 16'hFFFF);

        // FLDPI, FLDZ
        issue(8'h82); issue(8'h22);
        check("fldpi_data", bus.data_out, 80'h4000C90FDAA22168C235);
        issue(8'h81);
        check("fldz_tags", bus.tag_word_out, 16'h7FFF);
        issue(8'h22);
        check("fldz_data", bus.data_out, 80'h0);

        // Remaining constants, FST, FXCH, FLD ST(i), FLD m80
        issue(8'h83); issue(8'h84); issue(8'h85); issue(8'h86);
        issue(8'h21);
        check("ln2_data", bus.data_out, 80'h3FFEB17217F7D1CF79AC);
        issue(8'h23, 3'd2); issue(8'h21);
        check("fxch_data", bus.data_out, 80'h4000D49A784BCD1B8AFE);
        issue(8'h20, 3'd1); issue(8'h21);
        check("fld_sti_data", bus.data_out, 80'h3FFD9A209A84FBCFF799);
        issue(8'h20, 3'd0, 1'b1, 80'h4002A000000000000000); issue(8'h22);
        check("fld_mem_data", bus.data_out, 80'h4002A000000000000000);

        // Underflow through FXCH and FLD ST(i)
        issue(8'h01); issue(8'h80); issue(8'h23, 3'd3); issue(8'h21);
        check("fxch_empty_data", bus.data_out, INDEF);
        issue(8'h01); issue(8'h20, 3'd5);
        check("fld_empty_st0", dut.register_stack.st0, INDEF);

        // Overflow, masked then unmasked
        issue(8'h01);
        repeat (9) issue(8'h80);
        check("ovf_st0", dut.register_stack.st0, INDEF);
        check("ovf_status", bus.status_out, 16'h3A41);
        check("ovf_error", bus.error, 1'b0);
        issue(8'h01);
        set_control(16'h037E);
        repeat (9) issue(8'h80);
        check("ovf_unmasked_error", bus.error, 1'b1);
        check("ovf_unmasked_status", bus.status_out, 16'h3AC1);

        // FSTP on empty stack
        issue(8'h01); issue(8'h22);
        check("fstp_empty_data", bus.data_out, INDEF);
        check("fstp_empty_status", bus.status_out, 16'h0841);

        // FILD
        issue(8'h01);
        issue(8'h10, 3'd0, 1'b1, '0, 32'hFFFF_FFFB);
        check("fild_m5", dut.register_stack.st0, 80'hC001A000000000000000);
        issue(8'h10, 3'd0, 1'b1, '0, 32'd0);
        check("fild_0", dut.register_stack.st0, 80'h0);
        check("fild_0_tags", bus.tag_word_out, 16'h1FFF);
        issue(8'h10, 3'd0, 1'b1, '0, 32'h8000_0000);
        check("fild_min", dut.register_stack.st0, 80'hC01E8000000000000000);
        issue(8'h10, 3'd0, 1'b1, '0, 32'd1);
        check("fild_1", dut.register_stack.st0, 80'h3FFF8000000000000000);
        issue(8'h10, 3'd0, 1'b1, '0, 32'h7FFF_FFFF);
        issue(8'h10, 3'd0, 1'b1, '0, 32'd12345);

        // BCD qualifier, unsupported opcode, FNOP
        issue(8'h01);
        issue(8'h80, 3'd0, 1'b0, '0, '0, 1'b1);
        check("bcd_status", bus.status_out, 16'h0001);
        check("bcd_tags", bus.tag_word_out, 16'hFFFF);
        issue(8'h01); issue(8'h55);
        check("unsup_status", bus.status_out, 16'h0001);
        issue(8'h00);

        // control_write beats FINIT
        issue(8'h01, 3'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 16'h0272);
        check("cw_finit_control", bus.control_out, 16'h0272);
        issue(8'h01);

        // execute held through the busy cycle is accepted once
        issue(8'h80, 3'd0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("hold_tags", bus.tag_word_out, 16'h3FFF);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.instruction = 8'h82; bus.execute = 1'b1;
        @(posedge clk);
        m_exec(8'h82, 3'd0, 1'b0, '0, '0, 1'b0);
        exp_ready = 1'b0;
        @(negedge clk);
        bus.execute = 1'b0; reset = 1'b1;
        @(posedge clk);
        m_reset();
        exp_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_tags", bus.tag_word_out, 16'hFFFF);
        check("midreset_st0", dut.register_stack.st0, 80'h0);
        issue(8'h86); issue(8'h22);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
